// File: rtl/radix2_bf_pipe_if.sv
// Streaming port bundle for the radix-2 butterfly: input beat (A, B, W) and output beat (X, Y, clamp flag).
// The slave modport is the butterfly's view; the master modport is the producer/consumer view.
interface radix2_bf_pipe_if #(
    parameter int BW = 16,
    parameter int TW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [BW-1:0] in_a_re;
    logic signed [BW-1:0] in_a_im;
    logic signed [BW-1:0] in_b_re;
    logic signed [BW-1:0] in_b_im;
    logic signed [TW-1:0] in_tw_re;
    logic signed [TW-1:0] in_tw_im;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [BW:0]   out_x_re;
    logic signed [BW:0]   out_x_im;
    logic signed [BW:0]   out_y_re;
    logic signed [BW:0]   out_y_im;
    logic                 out_bw_sat;

    modport slave (
        input  in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_tw_re, in_tw_im, out_ready,
        output in_ready, out_valid, out_x_re, out_x_im, out_y_re, out_y_im, out_bw_sat
    );

    modport master (
        output in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_tw_re, in_tw_im, out_ready,
        input  in_ready, out_valid, out_x_re, out_x_im, out_y_re, out_y_im, out_bw_sat
    );
endinterface

// File: rtl/radix2_bf_pipe.sv
// Three-stage radix-2 DIT butterfly X = A + B*W, Y = A - B*W with one guard bit on the outputs.
// B*W is rounded half-up and clamped to BW bits; clamped beats are counted in a saturating counter.
module radix2_bf_pipe #(
    parameter int BW    = 16,
    parameter int TW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    radix2_bf_pipe_if.slave  bus,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_cnt
);

    localparam int PW = BW + TW;
    localparam logic signed [PW:0]    RND_C     = {{(BW + 2){1'b0}}, 1'b1, {(TW - 2){1'b0}}};
    localparam logic signed [PW:0]    MAX_C     = {{(TW + 2){1'b0}}, {(BW - 1){1'b1}}};
    localparam logic signed [PW:0]    MIN_C     = {{(TW + 2){1'b1}}, {(BW - 1){1'b0}}};
    localparam logic [CNT_W-1:0]      CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE_C = {{(CNT_W - 1){1'b0}}, 1'b1};

    // Returns {clamped_flag, value} for a rounded product component.
    function automatic logic [BW:0] clamp_f(input logic signed [PW:0] v);
        logic [BW:0] r;
        if (v > MAX_C) begin
            r = {1'b1, MAX_C[BW-1:0]};
        end else if (v < MIN_C) begin
            r = {1'b1, MIN_C[BW-1:0]};
        end else begin
            r = {1'b0, v[BW-1:0]};
        end
        return r;
    endfunction

    logic ce_s;

    logic          v1_q, v1_d;
    logic [BW-1:0] a1_re_q, a1_re_d, a1_im_q, a1_im_d;
    logic [PW-1:0] prr_q, prr_d, pii_q, pii_d, pri_q, pri_d, pir_q, pir_d;
    logic [PW-1:0] b_re_ext_s, b_im_ext_s, w_re_ext_s, w_im_ext_s;

    logic              v2_q, v2_d, sat2_q, sat2_d;
    logic [BW-1:0]     a2_re_q, a2_re_d, a2_im_q, a2_im_d;
    logic [BW-1:0]     bw_re_q, bw_re_d, bw_im_q, bw_im_d;
    logic signed [PW:0] p_re_s, p_im_s, sh_re_s, sh_im_s;
    logic [BW:0]       cl_re_s, cl_im_s;

    logic          v3_q, v3_d, sat3_q, sat3_d;
    logic [BW:0]   x_re_q, x_re_d, x_im_q, x_im_d, y_re_q, y_re_d, y_im_q, y_im_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The whole pipeline advances together whenever the output register is free or being drained.
    assign ce_s         = ~v3_q | bus.out_ready;
    assign bus.in_ready = ce_s;

    assign bus.out_valid  = v3_q;
    assign bus.out_x_re   = x_re_q;
    assign bus.out_x_im   = x_im_q;
    assign bus.out_y_re   = y_re_q;
    assign bus.out_y_im   = y_im_q;
    assign bus.out_bw_sat = sat3_q;
    assign sat_cnt        = cnt_q;

    // Stage 1: full-width partial products on sign-extended operands.
    always_comb begin
        b_re_ext_s = {{TW{bus.in_b_re[BW-1]}}, bus.in_b_re};
        b_im_ext_s = {{TW{bus.in_b_im[BW-1]}}, bus.in_b_im};
        w_re_ext_s = {{BW{bus.in_tw_re[TW-1]}}, bus.in_tw_re};
        w_im_ext_s = {{BW{bus.in_tw_im[TW-1]}}, bus.in_tw_im};
        if (ce_s) begin
            v1_d    = bus.in_valid;
            a1_re_d = bus.in_a_re;
            a1_im_d = bus.in_a_im;
            prr_d   = b_re_ext_s * w_re_ext_s;
            pii_d   = b_im_ext_s * w_im_ext_s;
            pri_d   = b_re_ext_s * w_im_ext_s;
            pir_d   = b_im_ext_s * w_re_ext_s;
        end else begin
            v1_d    = v1_q;
            a1_re_d = a1_re_q;
            a1_im_d = a1_im_q;
            prr_d   = prr_q;
            pii_d   = pii_q;
            pri_d   = pri_q;
            pir_d   = pir_q;
        end
    end

    // Stage 2: complex product, round half-up back to Q0, clamp to BW bits.
    always_comb begin
        p_re_s  = {prr_q[PW-1], prr_q} - {pii_q[PW-1], pii_q};
        p_im_s  = {pri_q[PW-1], pri_q} + {pir_q[PW-1], pir_q};
        sh_re_s = (p_re_s + RND_C) >>> (TW - 1);
        sh_im_s = (p_im_s + RND_C) >>> (TW - 1);
        cl_re_s = clamp_f(sh_re_s);
        cl_im_s = clamp_f(sh_im_s);
        if (ce_s) begin
            v2_d    = v1_q;
            a2_re_d = a1_re_q;
            a2_im_d = a1_im_q;
            bw_re_d = cl_re_s[BW-1:0];
            bw_im_d = cl_im_s[BW-1:0];
            sat2_d  = cl_re_s[BW] | cl_im_s[BW];
        end else begin
            v2_d    = v2_q;
            a2_re_d = a2_re_q;
            a2_im_d = a2_im_q;
            bw_re_d = bw_re_q;
            bw_im_d = bw_im_q;
            sat2_d  = sat2_q;
        end
    end

    // Stage 3: exact guard-bit sum/difference, plus the clamp-event counter.
    always_comb begin
        if (ce_s) begin
            v3_d   = v2_q;
            sat3_d = sat2_q;
            x_re_d = {a2_re_q[BW-1], a2_re_q} + {bw_re_q[BW-1], bw_re_q};
            x_im_d = {a2_im_q[BW-1], a2_im_q} + {bw_im_q[BW-1], bw_im_q};
            y_re_d = {a2_re_q[BW-1], a2_re_q} - {bw_re_q[BW-1], bw_re_q};
            y_im_d = {a2_im_q[BW-1], a2_im_q} - {bw_im_q[BW-1], bw_im_q};
        end else begin
            v3_d   = v3_q;
            sat3_d = sat3_q;
            x_re_d = x_re_q;
            x_im_d = x_im_q;
            y_re_d = y_re_q;
            y_im_d = y_im_q;
        end
        if (sat_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (v3_q && bus.out_ready && sat3_q && (cnt_q != CNT_MAX_C)) begin
            cnt_d = cnt_q + CNT_ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline and counter state; reset discards every in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            a1_re_q <= {BW{1'b0}};
            a1_im_q <= {BW{1'b0}};
            prr_q   <= {PW{1'b0}};
            pii_q   <= {PW{1'b0}};
            pri_q   <= {PW{1'b0}};
            pir_q   <= {PW{1'b0}};
            v2_q    <= 1'b0;
            a2_re_q <= {BW{1'b0}};
            a2_im_q <= {BW{1'b0}};
            bw_re_q <= {BW{1'b0}};
            bw_im_q <= {BW{1'b0}};
            sat2_q  <= 1'b0;
            v3_q    <= 1'b0;
            sat3_q  <= 1'b0;
            x_re_q  <= {(BW + 1){1'b0}};
            x_im_q  <= {(BW + 1){1'b0}};
            y_re_q  <= {(BW + 1){1'b0}};
            y_im_q  <= {(BW + 1){1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            v1_q    <= v1_d;
            a1_re_q <= a1_re_d;
            a1_im_q <= a1_im_d;
            prr_q   <= prr_d;
            pii_q   <= pii_d;
            pri_q   <= pri_d;
            pir_q   <= pir_d;
            v2_q    <= v2_d;
            a2_re_q <= a2_re_d;
            a2_im_q <= a2_im_d;
            bw_re_q <= bw_re_d;
            bw_im_q <= bw_im_d;
            sat2_q  <= sat2_d;
            v3_q    <= v3_d;
            sat3_q  <= sat3_d;
            x_re_q  <= x_re_d;
            x_im_q  <= x_im_d;
            y_re_q  <= y_re_d;
            y_im_q  <= y_im_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
